// File: rtl/display_pkg.sv
// Shared widths, BCD digit type and active-high seven-segment patterns
// (segment a in bit 0) for the slow_clk_monitor display path.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned LVL_W      = 3;
  localparam int unsigned BAR_W      = 6;
  localparam int unsigned BCD_W      = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Digit code that renders as "E" for an out-of-range level.
  localparam bcd_t CODE_E = 4'hE;

endpackage

// File: rtl/slow_clk_monitor_if.sv
// Board-facing signal bundle of the slow_clk_monitor: throttle inputs and
// display/LED outputs.
interface slow_clk_monitor_if;
  import display_pkg::*;

  logic                  slow_clk;
  logic [LVL_W-1:0]      freq_num;
  logic                  clear;
  logic [SEG_W-1:0]      seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] an;
  logic [BAR_W-1:0]      level_bar;
  logic                  tick_led;

  modport master (
    output slow_clk, freq_num, clear,
    input  seg, dp, an, level_bar, tick_led
  );

  modport slave (
    input  slow_clk, freq_num, clear,
    output seg, dp, an, level_bar, tick_led
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-high seven-segment pattern; codes
// other than 0-9 and "E" render blank.
module seg7_decode
  import display_pkg::*;
(
  input  bcd_t             code_i,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (code_i)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      CODE_E:  seg_c = SEG_E;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/slow_clk_monitor.sv
// Counts synchronized slow_clk rising edges in a 3-digit BCD counter and
// scans level + count onto a 4-digit display, with level bar and tick LED.
module slow_clk_monitor
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned MAX_LEVEL      = 5,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               CLK_50,
  input  logic               reset,
  slow_clk_monitor_if.slave  bus
);

  localparam int unsigned PRE_W = (SCAN_DIV > 32'd1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SEL_W = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 32'd1);
  localparam logic [LVL_W-1:0] MAX_LVL  = LVL_W'(MAX_LEVEL);
  localparam logic [SEG_W-1:0] SEG_OFF  = {SEG_W{SEG_ACTIVE_LOW}};

  logic [2:0]            sync_q;
  logic                  tick_q;
  logic [LVL_W-1:0]      lvl_q;
  bcd_t [2:0]            cnt_q, cnt_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [BAR_W-1:0]      bar_q, bar_d;
  logic                  led_q;

  logic                  lvl_chg_c;
  logic                  tc_c;
  bcd_t                  dig_c;
  logic [SEG_W-1:0]      dig_seg_c;

  seg7_decode u_dec (
    .code_i (dig_c),
    .seg_c  (dig_seg_c)
  );

  // Next-state: counter priority, scan prescaler, digit mux, level bar.
  always_comb begin
    lvl_chg_c = (bus.freq_num != lvl_q);
    tc_c      = (pre_q == PRE_LAST);
    cnt_d     = cnt_q;
    pre_d     = tc_c ? '0 : pre_q + PRE_W'(1);
    sel_d     = tc_c ? sel_q + SEL_W'(1) : sel_q;
    an_d      = an_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    bar_d     = '0;
    dig_c     = cnt_q[0];

    if (bus.clear || lvl_chg_c) begin
      cnt_d = '0;
    end else if (tick_q) begin
      // Digit-wise BCD carry; 999 wraps to 000.
      if (cnt_q[0] == 4'd9) begin
        cnt_d[0] = 4'd0;
        if (cnt_q[1] == 4'd9) begin
          cnt_d[1] = 4'd0;
          cnt_d[2] = (cnt_q[2] == 4'd9) ? 4'd0 : cnt_q[2] + 4'd1;
        end else begin
          cnt_d[1] = cnt_q[1] + 4'd1;
        end
      end else begin
        cnt_d[0] = cnt_q[0] + 4'd1;
      end
    end

    case (sel_q)
      2'd0: dig_c = cnt_q[0];
      2'd1: dig_c = cnt_q[1];
      2'd2: dig_c = cnt_q[2];
      2'd3: dig_c = (lvl_q > MAX_LVL) ? CODE_E : {1'b0, lvl_q};
      default: dig_c = cnt_q[0];
    endcase

    if (tc_c) begin
      an_d  = ~(NUM_DIGITS'(1) << sel_q);
      seg_d = SEG_ACTIVE_LOW ? ~dig_seg_c : dig_seg_c;
      dp_d  = (sel_q == SEL_W'(NUM_DIGITS - 1)) ^ SEG_ACTIVE_LOW;
    end

    for (int i = 0; i < int'(BAR_W); i++) begin
      bar_d[i] = (LVL_W'(i) < bus.freq_num);
    end
  end

  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      tick_q <= 1'b0;
      lvl_q  <= '0;
      cnt_q  <= '0;
      pre_q  <= '0;
      sel_q  <= '0;
      an_q   <= '1;
      seg_q  <= SEG_OFF;
      dp_q   <= SEG_ACTIVE_LOW;
      bar_q  <= '0;
      led_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.slow_clk};
      tick_q <= sync_q[1] & ~sync_q[2];
      lvl_q  <= bus.freq_num;
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      sel_q  <= sel_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      bar_q  <= bar_d;
      led_q  <= led_q ^ tick_q;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.an        = an_q;
  assign bus.level_bar = bar_q;
  assign bus.tick_led  = led_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Self-checking bench: directed scenarios plus random slow_clk/level/clear
// traffic checked every cycle against an arithmetic model of the display.
module tb_slow_clk_monitor;

  localparam int SD = 4;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  slow_clk_monitor_if bus ();

  slow_clk_monitor #(
    .SCAN_DIV       (SD),
    .MAX_LEVEL      (5),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK_50 (clk),
    .reset  (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs produced by the model
  int         m_count = 0;
  int         m_lvl   = 0;
  int         m_k     = 0;
  bit         m_led   = 1'b0;
  bit [4:1]   m_hist  = '0;
  logic [6:0] e_seg   = 7'h7F;
  logic       e_dp    = 1'b1;
  logic [3:0] e_an    = 4'hF;
  logic [5:0] e_bar   = '0;

  // Active-low segment pattern for a digit value (14 = "E").
  function automatic logic [6:0] pat(input int v);
    case (v)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      14: return 7'b0000110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Behavioural model: edge-indexed rules for count, scan slot and level.
  initial begin : model
    int  d;
    int  v;
    bit  tk;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_count = 0; m_lvl = 0; m_k = 0; m_led = 1'b0; m_hist = '0;
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_bar = '0;
      end else begin
        // A rise seen 3 edges ago (0 four edges ago) counts at this edge.
        tk  = m_hist[3] && !m_hist[4];
        m_k = m_k + 1;
        if (m_k % SD == 0) begin
          d = (m_k / SD - 1) % 4;
          case (d)
            0: v = m_count % 10;
            1: v = (m_count / 10) % 10;
            2: v = m_count / 100;
            default: v = (m_lvl > 5) ? 14 : m_lvl;
          endcase
          e_an  = ~(4'b0001 << d);
          e_seg = pat(v);
          e_dp  = (d == 3) ? 1'b0 : 1'b1;
        end
        if (bus.clear || (int'(bus.freq_num) != m_lvl)) m_count = 0;
        else if (tk) m_count = (m_count + 1) % 1000;
        if (tk) m_led = !m_led;
        m_lvl  = int'(bus.freq_num);
        e_bar  = (m_lvl >= 6) ? 6'h3F : 6'((1 << m_lvl) - 1);
        m_hist = {m_hist[3:1], bus.slow_clk};
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial begin : compare
    forever begin
      @(posedge clk);
      #1;
      chk("cyc_seg", bus.seg, e_seg);
      chk("cyc_dp", bus.dp, e_dp);
      chk("cyc_an", bus.an, e_an);
      chk("cyc_bar", bus.level_bar, e_bar);
      chk("cyc_led", bus.tick_led, m_led);
    end
  end

  task automatic pulse(input int hi, input int lo);
    bus.slow_clk = 1'b1;
    repeat (hi) @(negedge clk);
    bus.slow_clk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse(2, 2);
  endtask

  // Wait past a full scan, then find the slot for digit d and check it.
  task automatic check_digit(input int d, input logic [6:0] es, input string nm);
    logic [3:0] want;
    bit         found;
    want  = ~(4'b0001 << d);
    found = 1'b0;
    repeat (4 * SD + 1) @(posedge clk);
    for (int i = 0; i < 8 * SD && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.an == want) found = 1'b1;
    end
    chk({nm, "_an"}, bus.an, want);
    chk({nm, "_seg"}, bus.seg, es);
    chk({nm, "_dp"}, bus.dp, (d == 3) ? 1'b0 : 1'b1);
    @(negedge clk);
  endtask

  task automatic release_and_check_scan();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("scan_blank0", bus.an, 4'hF);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1 chk("scan_blank", bus.an, 4'hF);
    end
    @(posedge clk);
    #1 chk("scan_first", bus.an, 4'hE);
    @(negedge clk);
  endtask

  initial begin : timeout
    #1_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

  initial begin : stim
    rst_n        = 1'b1;
    bus.slow_clk = 1'b0;
    bus.freq_num = 3'd3;
    bus.clear    = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    release_and_check_scan();

    // Counting at level 3
    for (int i = 0; i < 7; i++) pulse(4, 4);
    chk("cnt7_model", m_count, 7);
    chk("cnt7_led", bus.tick_led, 1'b1);
    chk("cnt7_bar", bus.level_bar, 6'b000111);
    check_digit(0, 7'b1111000, "cnt7_d0");
    check_digit(3, 7'b0110000, "cnt7_d3");

    // Clear priority at 123
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    pulses(123);
    chk("c123_model", m_count, 123);
    check_digit(2, 7'b1111001, "c123_d2");
    bus.slow_clk = 1'b1;
    repeat (2) @(negedge clk);
    bus.slow_clk = 1'b0;
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1 chk("clr_tick_model", m_count, 0);
    @(negedge clk);
    pulses(3);
    bus.clear = 1'b0;
    @(negedge clk);
    chk("clr_hold_model", m_count, 0);
    check_digit(0, 7'b1000000, "clr_d0");
    check_digit(1, 7'b1000000, "clr_d1");
    check_digit(2, 7'b1000000, "clr_d2");

    // Level change 2 -> 4 at 015, then out-of-range 7
    bus.freq_num = 3'd2;
    @(negedge clk);
    pulses(15);
    chk("lvl15_model", m_count, 15);
    bus.freq_num = 3'd4;
    @(posedge clk);
    #1 chk("lvl4_bar", bus.level_bar, 6'b001111);
    chk("lvl4_model", m_count, 0);
    check_digit(0, 7'b1000000, "lvl4_d0");
    bus.freq_num = 3'd7;
    check_digit(3, 7'b0000110, "lvl7_d3");
    chk("lvl7_bar", bus.level_bar, 6'b111111);

    // Reset mid-run at 042
    bus.freq_num = 3'd1;
    @(negedge clk);
    pulses(42);
    chk("c42_model", m_count, 42);
    rst_n = 1'b0;
    #1;
    chk("rst_an", bus.an, 4'hF);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_dp", bus.dp, 1'b1);
    chk("rst_bar", bus.level_bar, 6'd0);
    chk("rst_led", bus.tick_led, 1'b0);
    repeat (2) @(negedge clk);
    release_and_check_scan();

    // Wrap 998 -> 999 -> 000
    pulses(998);
    chk("w998_model", m_count, 998);
    pulse(2, 2);
    check_digit(0, 7'b0010000, "w999_d0");
    check_digit(2, 7'b0010000, "w999_d2");
    pulse(2, 2);
    chk("w000_model", m_count, 0);
    check_digit(0, 7'b1000000, "w000_d0");
    check_digit(1, 7'b1000000, "w000_d1");
    check_digit(2, 7'b1000000, "w000_d2");

    // Single-cycle glitches
    for (int i = 0; i < 3; i++) pulse(1, 5);

    // Random traffic
    repeat (250) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) bus.freq_num = 3'($urandom_range(0, 7));
      bus.clear = (r == 1);
      if ($urandom_range(0, 14) == 0) pulse(1, int'($urandom_range(2, 5)));
      else pulse(int'($urandom_range(2, 5)), int'($urandom_range(2, 5)));
    end
    bus.clear = 1'b0;
    repeat (4 * SD + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slow_clk_monitor.md
# slow_clk_monitor

Display-side stage that consumes the divided `slow_clk` and the selected `freq_num` level produced by the throttle/clock-divider stage. It counts `slow_clk` rising edges in a 3-digit BCD counter and shows the current level plus the count on a 4-digit multiplexed seven-segment display. It also drives a level bar and an activity LED, so the board gives direct visual confirmation of the throttle setting.

## Interface
- `SCAN_DIV`, 50000, `CLK_50` cycles per digit slot (1 kHz scan at 50 MHz); legal range 2..2^20.
- `MAX_LEVEL`, 5, highest legal `freq_num`; larger values are out-of-range.
- `SEG_ACTIVE_LOW`, 1, 1 = segment driven low when lit, 0 = high when lit.

- `CLK_50` in 1: single system clock, 50 MHz.
- `reset` in 1: asynchronous, active-low reset (0 = in reset), deasserted synchronously by the board reset logic.
- `slow_clk` in 1: divided clock from the throttle stage, sampled as data, never used as a clock.
- `freq_num` in 3: current throttle level, 0..`MAX_LEVEL`.
- `clear` in 1: synchronous, level-sensitive count clear.
- `seg` out 7: segments a..g; `seg[0]`=a.
- `dp` out 1: decimal point, same polarity as `seg`.
- `an` out 4: digit enables, active-low, one-hot-low; `an[3]` = leftmost digit.
- `level_bar` out 6: thermometer of `freq_num`.
- `tick_led` out 1: toggles once per counted `slow_clk` edge.

## Operation
- **Input sync:** `slow_clk` passes through a 2-FF synchronizer, then a third register for edge detect. `tick` is a one-cycle pulse on synchronized 0→1.
- **Level register:** `freq_num` is registered each cycle into `lvl_q`. `lvl_chg` is asserted when the new sample differs from `lvl_q`.
- **Event counter:** three BCD digits `d2 d1 d0`, range 000..999.
  - On `tick`: increment, with digit-wise carry.
  - 999 + tick → 000 (wrap, no sticky overflow).
- **Counter priority:** `clear` or `lvl_chg` → 000. Clear wins over a simultaneous `tick`; the tick is dropped, not deferred.
- **Digit 3:** shows `lvl_q` as 0..5. If `lvl_q` > `MAX_LEVEL`, it shows "E" (segments a,d,e,f,g).
- **Digit mapping:** digits 2..0 show `d2 d1 d0`, no leading-zero blanking.
- **Decimal point:** `dp` is lit only while digit 3 is selected.
- **Scan:**
  - Prescaler counts 0..`SCAN_DIV`-1.
  - At the terminal count, `dig_sel` advances 0→1→2→3→0.
  - `an` = ~(1<<`dig_sel`).
  - `seg`/`dp` are decoded from the selected digit and registered with `an`, so they switch on the same edge.
- **level_bar:** bit i set iff i < `lvl_q`. `lvl_q` ≥ 6 → 6'b111111.
- **tick_led:** T-flop toggled by `tick`; not affected by `clear`.

## Timing
- **Reset values (async, while `reset`=0):**
  - sync/edge regs 0, `tick` 0
  - `lvl_q` 0, counter 000
  - prescaler 0, `dig_sel` 0
  - `an` 4'b1111 (all off)
  - `seg`/`dp` unlit (all 1 when `SEG_ACTIVE_LOW`)
  - `level_bar` 0, `tick_led` 0
- **Scan start:** the display stays blank until the first prescaler terminal count, `SCAN_DIV` cycles after reset release. At that edge `an`=4'b1110, showing digit 0.
- **Tick latency:** a `slow_clk` rise sampled on edge N gives `tick` high during cycle N+2. The counter and `tick_led` update on edge N+3.
- **slow_clk high/low:** minimum 2 `CLK_50` cycles each. Narrower pulses may be missed; this is not an error.
- **freq_num latency:** `freq_num` change at edge N → `lvl_q`/`level_bar` updated at N+1 → counter cleared at N+1.
- **Display update:** counter/level changes appear on the display at the next `dig_sel` visit of that digit, within ≤ 4·`SCAN_DIV` cycles.
- **Reset mid-scan:** all state returns to its reset value immediately. No partial digit is held.

## Structure
- **Package `display_pkg`:**
  - `SEG_*` constants for 0-9 and "E" (active-high form; polarity applied at output)
  - `NUM_DIGITS`=4
  - `bcd_t` typedef (4-bit)
- **Sub-module `seg7_decode`:** combinational BCD/code → 7-bit active-high pattern, instantiated once on the muxed digit.
- **Top module:** sync, edge detect, level register, BCD counter, scan prescaler, output registers.

## Test plan
Bench uses `SCAN_DIV`=4 and `SEG_ACTIVE_LOW`=1.
- **Reset:** `reset`=0 mid-run with count 042 → all outputs at reset values the same cycle; after release, `an`=1111 for 4 cycles, then 1110.
- **Counting:** 7 `slow_clk` pulses (4 high/4 low) at `freq_num`=3 → count 007, `tick_led`=1. Digit 0 `seg`=7'b1111000, digit 3 `seg`=7'b0110000 with `dp`=0, `level_bar`=6'b000111.
- **Wrap:** preload 998 via 998 pulses, then 2 more → 999 then 000; digits 2..0 all show `seg`=7'b1000000.
- **Clear priority:** `clear`=1 in the same cycle as `tick` at count 123 → 000 next edge; the count stays 000 while `clear` is held through further ticks.
- **Level change:** `freq_num` 2→4 at count 015 → count 000 and `level_bar`=6'b001111 one cycle later. `freq_num`=7 → digit 3 shows "E" (7'b0000110), `level_bar`=6'b111111.
- **Glitch:** a 1-cycle `slow_clk` high pulse does not corrupt state. The count increments by 0 or 1, never more.
